gba_ds_fifo: RTL and testbench

Direct Sound sample FIFO for one GBA Direct Sound channel (instantiate twice, A and B), on the writer side of the `FIFO_val`/`FIFO_re`/`FIFO_clr`/`FIFO_size` interface consumed by `direct_sound`. It accepts CPU/DMA writes to the FIFO_A/FIFO_B registers and assembles byte- or halfword-lane writes into 32-bit words. It stores up to 8 words (32 samples) and presents the head word to the consumer in first-word-fall-through form.

---
 rtl/gba_ds_fifo.sv | 131 +++++++++++++
 tb/tb_gba_ds_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gba_ds_fifo.sv
// rtl/gba_ds_fifo.sv - Direct Sound sample FIFO (writer side) for one GBA sound channel
//
// Collects CPU/DMA writes to a FIFO_x register into 32-bit words and queues up to
// DEPTH of them. The consumer sees the head word first-word-fall-through style.
//
// Parameters:
//   DEPTH      word capacity (power of two, at most 8)
//
// Ports:
//   gba_clk    in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   wr_en      in   1   register write strobe, one cycle per access
//   wr_be      in   4   byte-lane enables, lane i = wr_data[8i+7:8i]
//   wr_data    in  32   lane-aligned write data
//   FIFO_re    in   1   pop pulse from the consumer
//   FIFO_clr   in   1   clear pulse from the consumer
//   FIFO_size  out  4   current word count, 0..DEPTH
//   FIFO_val   out 32   head word, 0 when empty
//   ovf_flag   out  1   sticky: a word was dropped because the FIFO was full
//
// Build option:
//   GBA_DS_FIFO_BYTE_WRITE_EN  when defined, any nonzero wr_be is accepted so single
//                              byte writes accumulate; otherwise only 1111, 0011 and
//                              1100 are honoured and anything else is ignored.

module gba_ds_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        gba_clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic        FIFO_re,
    input  logic        FIFO_clr,
    output logic [3:0]  FIFO_size,
    output logic [31:0] FIFO_val,
    output logic        ovf_flag
);

    localparam int         PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_FULL = 4'(DEPTH);
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [3:0]    r_count;
    logic [31:0]   r_stage;
    logic          r_ovf;

    logic          w_be_ok;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_store;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_merged;

`ifdef GBA_DS_FIFO_BYTE_WRITE_EN
    assign w_be_ok = (wr_be != 4'b0000);
`else
    assign w_be_ok = (wr_be == 4'b1111) || (wr_be == 4'b0011) || (wr_be == 4'b1100);
`endif

    assign w_accept = wr_en && w_be_ok;
    // Lane 3 is the last lane of any access sequence, so it closes the word.
    assign w_push   = w_accept && wr_be[3];
    assign w_full   = (r_count == C_FULL);
    assign w_empty  = (r_count == 4'd0);
    // A pop on an empty FIFO is ignored, even when a push lands in the same cycle.
    assign w_pop    = FIFO_re && !w_empty;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_store  = w_push && (!w_full || w_pop);

    always_comb begin
        w_merged = r_stage;
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                w_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge gba_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 4'd0;
            r_stage <= 32'h0;
            r_ovf   <= 1'b0;
        end else if (FIFO_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 4'd0;
            r_stage <= 32'h0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_stage <= w_merged;
            end
            if (w_store) begin
                r_wptr <= (r_wptr == C_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Array contents survive reset and clear; the count alone decides validity.
    always_ff @(posedge gba_clk) begin
        if (w_store && !FIFO_clr) begin
            r_mem[r_wptr] <= w_merged;
        end
    end

    assign FIFO_size = r_count;
    assign FIFO_val  = w_empty ? 32'h0 : r_mem[r_rptr];
    assign ovf_flag  = r_ovf;

endmodule

// File: tb/tb_gba_ds_fifo.sv
// tb/tb_gba_ds_fifo.sv - self-checking bench for gba_ds_fifo

module tb_gba_ds_fifo;

    localparam int DEPTH = 8;

    logic        gba_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en   = 1'b0;
    logic [3:0]  wr_be   = 4'b0;
    logic [31:0] wr_data = 32'h0;
    logic        FIFO_re  = 1'b0;
    logic        FIFO_clr = 1'b0;
    logic [3:0]  FIFO_size;
    logic [31:0] FIFO_val;
    logic        ovf_flag;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit [31:0] mq[$];
    bit [31:0] mstage;
    bit        movf;

    gba_ds_fifo #(.DEPTH(DEPTH)) dut (
        .gba_clk  (gba_clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .FIFO_re  (FIFO_re),
        .FIFO_clr (FIFO_clr),
        .FIFO_size(FIFO_size),
        .FIFO_val (FIFO_val),
        .ovf_flag (ovf_flag)
    );

    always #5 gba_clk = ~gba_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit be_legal(input logic [3:0] be);
`ifdef GBA_DS_FIFO_BYTE_WRITE_EN
        return be != 4'b0000;
`else
        return be == 4'b1111 || be == 4'b0011 || be == 4'b1100;
`endif
    endfunction

    // Queue-level model of one clock edge.
    task automatic model_edge(input bit we, input logic [3:0] be, input logic [31:0] d,
                              input bit re, input bit clr);
        int  n;
        bit  pop_ok;
        if (clr) begin
            mq.delete();
            mstage = 0;
            movf   = 0;
            return;
        end
        n      = mq.size();
        pop_ok = re && n > 0;
        if (we && be_legal(be)) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mstage[8*i +: 8] = d[8*i +: 8];
        end
        if (pop_ok) void'(mq.pop_front());
        if (we && be_legal(be) && be[3]) begin
            if (n < DEPTH || pop_ok) mq.push_back(mstage);
            else                     movf = 1;
        end
    endtask

    task automatic step(input bit we, input logic [3:0] be, input logic [31:0] d,
                        input bit re, input bit clr);
        wr_en = we; wr_be = be; wr_data = d; FIFO_re = re; FIFO_clr = clr;
        @(posedge gba_clk);
        model_edge(we, be, d, re, clr);
        #1;
        wr_en = 0; wr_be = 0; wr_data = 0; FIFO_re = 0; FIFO_clr = 0;
    endtask

    task automatic wr(input logic [3:0] be, input logic [31:0] d);
        step(1, be, d, 0, 0);
    endtask

    task automatic pop();
        step(0, 4'b0, 32'h0, 1, 0);
    endtask

    always @(negedge gba_clk) begin
        if (chk_en) begin
            check("cyc_size", {28'h0, FIFO_size}, mq.size());
            check("cyc_val",  FIFO_val, (mq.size() > 0) ? mq[0] : 32'h0);
            check("cyc_ovf",  {31'h0, ovf_flag}, {31'h0, movf});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        mstage = 0; movf = 0;
        repeat (3) @(posedge gba_clk);
        #2 reset_n = 1'b1;
        @(posedge gba_clk); #1;
        check("rst_size", {28'h0, FIFO_size}, 32'd0);
        check("rst_val",  FIFO_val, 32'h0);
        check("rst_ovf",  {31'h0, ovf_flag}, 32'd0);
        chk_en = 1'b1;

        // Fill with 11111111..88888888
        for (int k = 1; k <= 8; k++) begin
            wr(4'b1111, 32'h11111111 * k);
            check("fill_size", {28'h0, FIFO_size}, k);
            check("fill_val",  FIFO_val, 32'h11111111);
            check("fill_ovf",  {31'h0, ovf_flag}, 32'd0);
        end
        wr(4'b1111, 32'hDEADBEEF);
        check("ovf_size", {28'h0, FIFO_size}, 32'd8);
        check("ovf_flag", {31'h0, ovf_flag}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            check("drain_val", FIFO_val, 32'h11111111 * k);
            pop();
        end
        check("empty_size", {28'h0, FIFO_size}, 32'd0);
        check("empty_val",  FIFO_val, 32'h0);
        pop();
        check("pop_empty_size", {28'h0, FIFO_size}, 32'd0);

        // Halfword assembly
        wr(4'b0011, 32'h00005678);
        check("hw1_size", {28'h0, FIFO_size}, 32'd0);
        wr(4'b1100, 32'hABCD0000);
        check("hw_val",  FIFO_val, 32'hABCD5678);
        check("hw_size", {28'h0, FIFO_size}, 32'd1);

        // Full with simultaneous pop+push, crossing the pointer wrap
        step(0, 4'b0, 32'h0, 0, 1);
        for (int k = 0; k < 8; k++) wr(4'b1111, 32'hA0000000 + k);
        step(1, 4'b1111, 32'h99999999, 1, 0);
        check("pp_size", {28'h0, FIFO_size}, 32'd8);
        check("pp_ovf",  {31'h0, ovf_flag}, 32'd0);
        check("pp_head", FIFO_val, 32'hA0000001);
        for (int k = 1; k < 8; k++) pop();
        check("pp_8th", FIFO_val, 32'h99999999);
        pop();
        check("pp_end_size", {28'h0, FIFO_size}, 32'd0);
        // Push into empty with a same-cycle pop: pop ignored
        step(1, 4'b1111, 32'h12345678, 1, 0);
        check("e_pp_size", {28'h0, FIFO_size}, 32'd1);
        check("e_pp_val",  FIFO_val, 32'h12345678);
        // Continue around the ring and back-to-back pop/push
        for (int k = 0; k < 5; k++) step(1, 4'b1111, 32'hC0000000 + k, 1, 0);
        check("ring_val", FIFO_val, 32'hC0000004);

        // Clear beats same-cycle pop and write
        for (int k = 0; k < 4; k++) wr(4'b1111, 32'hB0000000 + k);
        check("five_size", {28'h0, FIFO_size}, 32'd5);
        step(1, 4'b1111, 32'hFFFFFFFF, 1, 1);
        check("clr_size", {28'h0, FIFO_size}, 32'd0);
        check("clr_val",  FIFO_val, 32'h0);
        check("clr_ovf",  {31'h0, ovf_flag}, 32'd0);

        // Asynchronous reset mid-burst
        wr(4'b1111, 32'h0BADF00D);
        wr(4'b1111, 32'h0000CAFE);
        #1;
        reset_n = 1'b0;
        mq.delete(); mstage = 0; movf = 0;
        #1;
        check("arst_size", {28'h0, FIFO_size}, 32'd0);
        check("arst_val",  FIFO_val, 32'h0);
        check("arst_ovf",  {31'h0, ovf_flag}, 32'd0);
        @(posedge gba_clk);
        @(posedge gba_clk);
        #2 reset_n = 1'b1;
        @(posedge gba_clk); #1;

        // Byte-lane writes
        wr(4'b0001, 32'h00000001);
        wr(4'b0010, 32'h00000200);
        wr(4'b0100, 32'h00030000);
        wr(4'b1000, 32'h04000000);
`ifdef GBA_DS_FIFO_BYTE_WRITE_EN
        check("byte_val",  FIFO_val, 32'h04030201);
        check("byte_size", {28'h0, FIFO_size}, 32'd1);
`else
        check("byte_size", {28'h0, FIFO_size}, 32'd0);
        check("byte_val",  FIFO_val, 32'h0);
        // Ignored byte writes must not disturb staging
        wr(4'b0011, 32'h00002211);
        wr(4'b1100, 32'h44330000);
        check("after_byte_val", FIFO_val, 32'h44332211);
`endif
        @(negedge gba_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
